seq_div_32: RTL and testbench

SEQ_DIV_32 -- requirements
Module: seq_div_32

---
 rtl/seq_div_32.sv | 125 ++++++++++++
 tb/tb_seq_div_32.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_div_32.sv
// Sequential restoring divider: one quotient bit per clock, WIDTH steps per division.
// Results, done and div_by_zero are registered; done pulses in the cycle after the DONE state.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   s_val;
    logic [WIDTH:0]   sub_b;
    logic [WIDTH+1:0] sub_full;
    logic [WIDTH:0]   t_val;
    logic             cout;

    // One restoring step: S = shifted partial remainder, T = S - divisor; carry-out means S >= divisor
    always_comb begin
        s_val    = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
        sub_b    = ~{1'b0, dsr_q};
        sub_full = {1'b0, s_val} + {1'b0, sub_b} + {{(WIDTH + 1){1'b0}}, 1'b1};
        t_val    = sub_full[WIDTH:0];
        cout     = sub_full[WIDTH+1];
    end

    // Next-state and datapath control for IDLE / RUN / DONE
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dsr_d       = dsr_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dsr_d   = divisor;
                    rem_d   = '0;
                    quo_d   = dividend;
                    cnt_d   = '0;
                    dbz_d   = (divisor == '0);
                    state_d = (divisor == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                rem_d = cout ? t_val : s_val;
                quo_d = {quo_q[WIDTH-2:0], cout};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Zero divisor: Q still holds the untouched dividend, so it becomes the remainder
                done_d      = 1'b1;
                quotient_d  = dbz_q ? '1 : quo_q;
                remainder_d = dbz_q ? quo_q : rem_q[WIDTH-1:0];
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dsr_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dsr_q       <= dsr_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Self-checking bench for seq_div_32: directed table, multi-cycle corner sequences,
// and randomized checks on a 32-bit and a 4-bit instance against plain-arithmetic division.
module tb_seq_div_32;

    localparam int W  = 32;
    localparam int SW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;
    logic [W-1:0]  quotient, remainder;
    logic          busy, done, div_by_zero;

    logic          s_start = 1'b0;
    logic [SW-1:0] s_dividend = '0;
    logic [SW-1:0] s_divisor = '0;
    logic [SW-1:0] s_quotient, s_remainder;
    logic          s_busy, s_done, s_dbz;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int acc32    = 0;

    seq_div_32 #(.WIDTH(W)) u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    seq_div_32 #(.WIDTH(SW)) u_small (
        .clk         (clk),
        .reset       (reset),
        .start       (s_start),
        .dividend    (s_dividend),
        .divisor     (s_divisor),
        .quotient    (s_quotient),
        .remainder   (s_remainder),
        .busy        (s_busy),
        .done        (s_done),
        .div_by_zero (s_dbz)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           lat;
    } vec_t;

    vec_t vecs[11];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Present operands with start for one cycle; returns #1 after the accepting edge
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        acc32    = cyc;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
    endtask

    // Wait (bounded) for done; latency is edges counted from the accepting edge
    task automatic wait_done(output int lat);
        while (done !== 1'b1 && (cyc - acc32) < 100) begin
            @(posedge clk);
            #1;
        end
        lat = cyc - acc32;
    endtask

    function automatic logic [W-1:0] pick32();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'd1;
            2:       return '1;
            3:       return $urandom_range(0, 15);
            4:       return $urandom >> $urandom_range(0, 31);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int lat;
        int t_first;
        int pulses;
        logic [W-1:0] prev_q;

        vecs[0]  = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33};
        vecs[1]  = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0, 33};
        vecs[2]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 33};
        vecs[3]  = '{32'd5,          32'd9,          32'd0,          32'd5,          1'b0, 33};
        vecs[4]  = '{32'h1234,       32'd0,          32'hFFFF_FFFF,  32'h1234,       1'b1, 1};
        vecs[5]  = '{32'd1000,       32'd10,         32'd100,        32'd0,          1'b0, 33};
        vecs[6]  = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1, 1};
        vecs[7]  = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33};
        vecs[8]  = '{32'h8000_0000,  32'h8000_0001,  32'd0,          32'h8000_0000,  1'b0, 33};
        vecs[9]  = '{32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0, 33};
        vecs[10] = '{32'h1234_5678,  32'h1000,       32'h0001_2345,  32'h678,        1'b0, 33};

        // Asynchronous reset before any clock edge
        #1 reset = 1'b1;
        #1;
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_dbz", div_by_zero, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            launch(vecs[i].a, vecs[i].b);
            wait_done(lat);
            check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
            check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
            check($sformatf("vec%0d_dbz", i), div_by_zero, vecs[i].z);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_one_cycle", i), done, 0);
        end

        // div_by_zero holds after done and clears on the next accepted start
        launch(32'd7, 32'd0);
        wait_done(lat);
        repeat (3) begin @(posedge clk); #1; end
        check("dbz_hold", div_by_zero, 1);
        check("dbz_hold_quotient", quotient, 32'hFFFF_FFFF);
        check("dbz_hold_remainder", remainder, 32'd7);
        launch(32'd9, 32'd3);
        check("dbz_clear_on_start", div_by_zero, 0);
        wait_done(lat);
        check("after_dbz_quotient", quotient, 32'd3);

        // start during RUN ignored; results not shown during RUN
        prev_q = quotient;
        launch(32'd100, 32'd7);
        repeat (10) begin @(posedge clk); #1; end
        check("busy_in_run", busy, 1);
        check("hold_quotient_in_run", quotient, prev_q);
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat);
        check("ignore_start_latency", lat, 33);
        check("ignore_start_quotient", quotient, 32'd14);
        check("ignore_start_remainder", remainder, 32'd2);
        pulses = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        check("ignore_start_not_queued", pulses, 0);

        // start held high: back-to-back divisions, one result per W+2 cycles
        @(negedge clk);
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(posedge clk);
        #1;
        acc32    = cyc;
        dividend = 32'd90;
        divisor  = 32'd9;
        wait_done(lat);
        check("b2b_first_latency", lat, 33);
        check("b2b_first_quotient", quotient, 32'd15);
        check("b2b_first_remainder", remainder, 32'd2);
        t_first = cyc;
        do begin
            @(posedge clk);
            #1;
        end while (done !== 1'b1 && (cyc - t_first) < 100);
        start = 1'b0;
        check("b2b_gap", cyc - t_first, 34);
        check("b2b_second_quotient", quotient, 32'd10);
        check("b2b_second_remainder", remainder, 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        check("b2b_stopped", busy, 0);

        // Reset in the middle of RUN abandons the division
        launch(32'd1234, 32'd5);
        repeat (15) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("midrun_reset_quotient", quotient, 0);
        check("midrun_reset_remainder", remainder, 0);
        check("midrun_reset_busy", busy, 0);
        check("midrun_reset_done", done, 0);
        check("midrun_reset_dbz", div_by_zero, 0);
        pulses = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        @(negedge clk) reset = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) pulses++;
        end
        check("midrun_reset_no_done", pulses, 0);
        launch(32'd1000, 32'd10);
        wait_done(lat);
        check("post_reset_latency", lat, 33);
        check("post_reset_quotient", quotient, 32'd100);
        check("post_reset_remainder", remainder, 32'd0);

        // Randomized checks on both instances in parallel
        fork
            begin
                for (int k = 0; k < 1200; k++) begin
                    logic [W-1:0] a, b, eq, er;
                    a  = pick32();
                    b  = pick32();
                    eq = (b == '0) ? '1 : a / b;
                    er = (b == '0) ? a : a % b;
                    launch(a, b);
                    wait_done(lat);
                    check("rand32_latency", lat, (b == '0) ? 1 : 33);
                    check("rand32_quotient", quotient, eq);
                    check("rand32_remainder", remainder, er);
                    check("rand32_dbz", div_by_zero, (b == '0));
                end
            end
            begin
                for (int k = 0; k < 8800; k++) begin
                    logic [SW-1:0] a, b, eq, er;
                    int s_acc;
                    a  = 4'($urandom_range(0, 15));
                    b  = 4'($urandom_range(0, 15));
                    eq = (b == '0) ? '1 : a / b;
                    er = (b == '0) ? a : a % b;
                    @(negedge clk);
                    s_start    = 1'b1;
                    s_dividend = a;
                    s_divisor  = b;
                    @(posedge clk);
                    #1;
                    s_acc      = cyc;
                    s_start    = 1'b0;
                    s_dividend = 4'($urandom);
                    s_divisor  = 4'($urandom);
                    while (s_done !== 1'b1 && (cyc - s_acc) < 20) begin
                        @(posedge clk);
                        #1;
                    end
                    check("rand4_latency", cyc - s_acc, (b == '0) ? 1 : SW + 1);
                    check("rand4_quotient", s_quotient, eq);
                    check("rand4_remainder", s_remainder, er);
                    check("rand4_dbz", s_dbz, (b == '0));
                end
            end
        join

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
